pu_riscv_ahb_biu: RTL

AMBA3 AHB-Lite master bus interface unit. Consumes the BIU request handshake from the data/instruction external access stages (stb/stb_ack address phase, ack/err data phase) and drives one AHB-Lite master port. It pipelines address and data phases, generates SEQ beats and addresses for fixed, incrementing and wrapping bursts, and handles the two-cycle ERROR response.

---
 rtl/pu_riscv_ahb_biu.sv | 228 ++++++++++++++++++++++
 1 files changed

// File: rtl/pu_riscv_ahb_biu.sv
// AHB-Lite master bus interface unit: converts the BIU stb/ack request handshake
// into pipelined AHB-Lite address/data phases with burst sequencing and ERROR handling.
module pu_riscv_ahb_biu #(
  parameter int XLEN = 64,
  parameter int PLEN = 64
) (
  input  logic            clk_i,
  input  logic            rst_ni,

  input  logic            biu_stb_i,
  output logic            biu_stb_ack_o,
  input  logic [PLEN-1:0] biu_adri_i,
  output logic [PLEN-1:0] biu_adro_o,
  input  logic [2:0]      biu_size_i,
  input  logic [2:0]      biu_type_i,
  input  logic            biu_lock_i,
  input  logic [2:0]      biu_prot_i,
  input  logic            biu_we_i,
  input  logic [XLEN-1:0] biu_d_i,
  output logic [XLEN-1:0] biu_q_o,
  output logic            biu_ack_o,
  output logic            biu_err_o,

  output logic            HSEL,
  output logic [PLEN-1:0] HADDR,
  output logic [XLEN-1:0] HWDATA,
  input  logic [XLEN-1:0] HRDATA,
  output logic            HWRITE,
  output logic [2:0]      HSIZE,
  output logic [2:0]      HBURST,
  output logic [3:0]      HPROT,
  output logic [1:0]      HTRANS,
  output logic            HMASTLOCK,
  input  logic            HREADY,
  input  logic            HRESP
);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_BUSY   = 2'b01;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;

  localparam logic [2:0] HB_SINGLE = 3'd0;
  localparam logic [2:0] HB_INCR   = 3'd1;
  localparam logic [2:0] HB_WRAP4  = 3'd2;
  localparam logic [2:0] HB_INCR4  = 3'd3;
  localparam logic [2:0] HB_WRAP8  = 3'd4;
  localparam logic [2:0] HB_INCR8  = 3'd5;
  localparam logic [2:0] HB_WRAP16 = 3'd6;
  localparam logic [2:0] HB_INCR16 = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_BURST = 2'b01,
    ST_ERR   = 2'b10
  } state_t;

  // Beats in a burst; 0 marks the unbounded INCR burst.
  function automatic logic [4:0] burst_beats(input logic [2:0] burst);
    logic [4:0] beats;
    case (burst)
      HB_SINGLE:           beats = 5'd1;
      HB_WRAP4, HB_INCR4:  beats = 5'd4;
      HB_WRAP8, HB_INCR8:  beats = 5'd8;
      HB_WRAP16, HB_INCR16: beats = 5'd16;
      default:             beats = 5'd0;
    endcase
    return beats;
  endfunction

  // Address of the following beat; wrapping bursts stay inside an n*size aligned block.
  function automatic logic [PLEN-1:0] next_addr(input logic [PLEN-1:0] addr,
                                                input logic [2:0]      size,
                                                input logic [2:0]      burst);
    logic [PLEN-1:0] step;
    logic [PLEN-1:0] sum;
    logic [PLEN-1:0] mask;
    step = PLEN'(1) << size;
    sum  = addr + step;
    case (burst)
      HB_WRAP4:  mask = (step << 2) - PLEN'(1);
      HB_WRAP8:  mask = (step << 3) - PLEN'(1);
      HB_WRAP16: mask = (step << 4) - PLEN'(1);
      default:   mask = '0;
    endcase
    return (mask == '0) ? sum : ((addr & ~mask) | (sum & mask));
  endfunction

  state_t          state_r, state_nxt_s, state_d_s;
  logic [4:0]      cnt_r;
  logic [PLEN-1:0] addr_r;
  logic [2:0]      size_r, burst_r, prot_r;
  logic            we_r, lock_r;
  logic [XLEN-1:0] hwdata_r;
  logic            dp_valid_r;
  logic            hsel_r;

  logic            err_start_s, cancel_s, stb_ack_s;
  logic [1:0]      htrans_s;
  logic [PLEN-1:0] haddr_s;
  logic            hwrite_s, hlock_s;
  logic [2:0]      hsize_s, hburst_s, hprot_s;

  // First ERROR cycle and the follow-up cycle both suppress any new address phase.
  assign err_start_s = dp_valid_r & HRESP & ~HREADY;
  assign cancel_s    = err_start_s | (state_r == ST_ERR);

  // Address-phase outputs and next-state selection.
  always_comb begin
    state_nxt_s = state_r;
    htrans_s    = HT_IDLE;
    haddr_s     = '0;
    hwrite_s    = 1'b0;
    hsize_s     = 3'd0;
    hburst_s    = 3'd0;
    hprot_s     = 3'd0;
    hlock_s     = 1'b0;
    stb_ack_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (biu_stb_i && hsel_r) begin
          htrans_s  = HT_NONSEQ;
          haddr_s   = biu_adri_i;
          hwrite_s  = biu_we_i;
          hsize_s   = biu_size_i;
          hburst_s  = biu_type_i;
          hprot_s   = biu_prot_i;
          hlock_s   = biu_lock_i;
          stb_ack_s = HREADY & ~cancel_s;
          if (stb_ack_s && (burst_beats(biu_type_i) != 5'd1)) begin
            state_nxt_s = ST_BURST;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_BURST: begin
        haddr_s  = addr_r;
        hwrite_s = we_r;
        hsize_s  = size_r;
        hburst_s = burst_r;
        hprot_s  = prot_r;
        hlock_s  = lock_r;
        if (biu_stb_i) begin
          htrans_s  = HT_SEQ;
          stb_ack_s = HREADY & ~cancel_s;
          if (stb_ack_s && (burst_r != HB_INCR) && (cnt_r == 5'd1)) begin
            state_nxt_s = ST_IDLE;
          end else begin
            state_nxt_s = ST_BURST;
          end
        end else if (burst_r == HB_INCR) begin
          htrans_s    = HT_IDLE;
          state_nxt_s = ST_IDLE;
        end else begin
          htrans_s    = HT_BUSY;
          state_nxt_s = ST_BURST;
        end
      end
      ST_ERR: begin
        if (HREADY) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ERR;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  assign state_d_s = err_start_s ? ST_ERR : state_nxt_s;

  // State, latched burst attributes, beat counter and data-phase tracking.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 5'd0;
      addr_r     <= '0;
      size_r     <= 3'd0;
      burst_r    <= 3'd0;
      prot_r     <= 3'd0;
      we_r       <= 1'b0;
      lock_r     <= 1'b0;
      hwdata_r   <= '0;
      dp_valid_r <= 1'b0;
      hsel_r     <= 1'b0;
    end else begin
      hsel_r  <= 1'b1;
      state_r <= state_d_s;
      if (stb_ack_s) begin
        hwdata_r   <= biu_d_i;
        dp_valid_r <= 1'b1;
        if (state_r == ST_IDLE) begin
          addr_r  <= next_addr(biu_adri_i, biu_size_i, biu_type_i);
          size_r  <= biu_size_i;
          burst_r <= biu_type_i;
          prot_r  <= biu_prot_i;
          we_r    <= biu_we_i;
          lock_r  <= biu_lock_i;
          cnt_r   <= burst_beats(biu_type_i) - 5'd1;
        end else begin
          addr_r <= next_addr(addr_r, size_r, burst_r);
          cnt_r  <= cnt_r - 5'd1;
        end
      end else if (HREADY) begin
        dp_valid_r <= 1'b0;
      end
    end
  end

  assign HSEL          = hsel_r;
  assign HTRANS        = cancel_s ? HT_IDLE : htrans_s;
  assign HADDR         = haddr_s;
  assign HWRITE        = hwrite_s;
  assign HSIZE         = hsize_s;
  assign HBURST        = hburst_s;
  assign HPROT         = {1'b0, hprot_s};
  assign HMASTLOCK     = hlock_s;
  assign HWDATA        = hwdata_r;
  assign biu_adro_o    = haddr_s;
  assign biu_stb_ack_o = stb_ack_s;
  assign biu_q_o       = HRDATA;
  assign biu_ack_o     = dp_valid_r & HREADY & ~HRESP;
  assign biu_err_o     = dp_valid_r & HREADY & HRESP;

endmodule
